// File: rtl/blocpu_program_loader.sv
// ---------------------------------------------------------------------------
// blocpu_program_loader
//   Byte-stream program loader for the blocpu core. Parses a framed byte
//   stream (magic 0xB1, base address, 16-bit count, count instruction pairs,
//   optional checksum). Each 12-bit instruction is written to instruction
//   memory at consecutive addresses. A successful frame ends with a one-cycle
//   start pulse that carries the base address.
//
//   Optional feature macro: LOADER_CHECKSUM_EN
//     defined   -> a checksum byte closes every frame. The 8-bit sum of
//                  addr_hi..checksum must be 0x00.
//     undefined -> there is no checksum byte and no CHECK state.
//
// Ports
//   clock, reset   rising-edge clock, async active-high reset
//   in_data/in_valid/in_ready   byte stream handshake
//   imem_write/imem_address/imem_data   registered memory write port
//   core_start/start_address   start request; the address is held after the pulse
//   busy    high whenever the FSM is not in IDLE
//   error   sticky frame error; cleared by reset or by an accepted magic byte
// ---------------------------------------------------------------------------
module blocpu_program_loader #(
    parameter int CPU_WIDTH         = 8,
    parameter int INSTRUCTION_WIDTH = 12,
    parameter int ADDRESS_WIDTH     = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [CPU_WIDTH-1:0]         in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic                         imem_write,
    output logic [ADDRESS_WIDTH-1:0]     imem_address,
    output logic [INSTRUCTION_WIDTH-1:0] imem_data,
    output logic                         core_start,
    output logic [ADDRESS_WIDTH-1:0]     start_address,
    output logic                         busy,
    output logic                         error
);

    localparam logic [7:0] MAGIC = 8'hB1;

    typedef enum logic [3:0] {
        IDLE,
        ADDR_HI,
        ADDR_LO,
        CNT_HI,
        CNT_LO,
        INST_HI,
        INST_LO,
`ifdef LOADER_CHECKSUM_EN
        CHECK,
`endif
        START
    } state_t;

    state_t                         state_q;
    logic [ADDRESS_WIDTH-1:0]       base_q;
    logic [ADDRESS_WIDTH-1:0]       addr_q;
    logic [15:0]                    cnt_q;
    logic [3:0]                     hi_q;
    logic [7:0]                     sum_q;
    logic                           imem_write_q;
    logic [ADDRESS_WIDTH-1:0]       imem_address_q;
    logic [INSTRUCTION_WIDTH-1:0]   imem_data_q;
    logic                           core_start_q;
    logic [ADDRESS_WIDTH-1:0]       start_address_q;
    logic                           error_q;

    // Ready drops combinationally with reset so that no byte is taken while
    // the loader is held in reset.
    assign in_ready      = !reset && (state_q != START);
    assign busy          = (state_q != IDLE);
    assign imem_write    = imem_write_q;
    assign imem_address  = imem_address_q;
    assign imem_data     = imem_data_q;
    assign core_start    = core_start_q;
    assign start_address = start_address_q;
    assign error         = error_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            base_q          <= '0;
            addr_q          <= '0;
            cnt_q           <= '0;
            hi_q            <= '0;
            sum_q           <= '0;
            imem_write_q    <= 1'b0;
            imem_address_q  <= '0;
            imem_data_q     <= '0;
            core_start_q    <= 1'b0;
            start_address_q <= '0;
            error_q         <= 1'b0;
        end else begin
            imem_write_q <= 1'b0;
            core_start_q <= 1'b0;
            if (state_q == START) begin
                // The pulse was raised on the edge that entered START, so it
                // lasts exactly the one cycle spent here.
                state_q <= IDLE;
            end else if (in_valid) begin
                // Running checksum. It is restarted on the magic byte, so it
                // covers addr_hi onward.
                sum_q <= sum_q + in_data;
                case (state_q)
                    IDLE: begin
                        if (in_data == MAGIC) begin
                            error_q <= 1'b0;
                            sum_q   <= '0;
                            state_q <= ADDR_HI;
                        end
                    end
                    ADDR_HI: begin
                        base_q[15:8] <= in_data;
                        state_q      <= ADDR_LO;
                    end
                    ADDR_LO: begin
                        base_q[7:0] <= in_data;
                        addr_q      <= {base_q[15:8], in_data};
                        state_q     <= CNT_HI;
                    end
                    CNT_HI: begin
                        cnt_q[15:8] <= in_data;
                        state_q     <= CNT_LO;
                    end
                    CNT_LO: begin
                        cnt_q[7:0] <= in_data;
                        if ({cnt_q[15:8], in_data} == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                            state_q <= CHECK;
`else
                            core_start_q    <= 1'b1;
                            start_address_q <= base_q;
                            state_q         <= START;
`endif
                        end else begin
                            state_q <= INST_HI;
                        end
                    end
                    INST_HI: begin
                        if (in_data[7:4] != 4'd0) begin
                            error_q <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            hi_q    <= in_data[3:0];
                            state_q <= INST_LO;
                        end
                    end
                    INST_LO: begin
                        imem_write_q   <= 1'b1;
                        imem_address_q <= addr_q;
                        imem_data_q    <= {hi_q, in_data};
                        addr_q         <= addr_q + 16'd1;  // wraps 0xFFFF -> 0x0000
                        cnt_q          <= cnt_q - 16'd1;
                        if (cnt_q == 16'd1) begin
`ifdef LOADER_CHECKSUM_EN
                            state_q <= CHECK;
`else
                            core_start_q    <= 1'b1;
                            start_address_q <= base_q;
                            state_q         <= START;
`endif
                        end else begin
                            state_q <= INST_HI;
                        end
                    end
`ifdef LOADER_CHECKSUM_EN
                    CHECK: begin
                        if (8'(sum_q + in_data) == 8'h00) begin
                            core_start_q    <= 1'b1;
                            start_address_q <= base_q;
                            state_q         <= START;
                        end else begin
                            error_q <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
`endif
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_blocpu_program_loader.sv
module tb_blocpu_program_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        imem_write;
    logic [15:0] imem_address;
    logic [11:0] imem_data;
    logic        core_start;
    logic [15:0] start_address;
    logic        busy;
    logic        error;

    blocpu_program_loader dut (
        .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .imem_write(imem_write), .imem_address(imem_address),
        .imem_data(imem_data), .core_start(core_start), .start_address(start_address),
        .busy(busy), .error(error)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [15:0] addr;
        logic [11:0] data;
    } wr_t;

    wr_t         exp_wr[$];
    logic [15:0] exp_st[$];
    logic [7:0]  fb[$];
    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every write strobe / start pulse must match the
    // oldest expected entry.
    always @(negedge clock) begin
        if (!reset) begin
            if (imem_write) begin
                vectors++;
                if (exp_wr.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_write: addr %h data %h", imem_address, imem_data);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    if (imem_address !== e.addr || imem_data !== e.data) begin
                        miscompares++;
                        $display("FAIL write: got %h<-%h expected %h<-%h",
                                 imem_address, imem_data, e.addr, e.data);
                    end
                end
            end
            if (core_start) begin
                vectors++;
                if (exp_st.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_start: start_address %h", start_address);
                end else begin
                    logic [15:0] s;
                    s = exp_st.pop_front();
                    if (start_address !== s) begin
                        miscompares++;
                        $display("FAIL start_address: got %h expected %h", start_address, s);
                    end
                end
            end
        end
    end

    function automatic wr_t w(input logic [15:0] a, input logic [11:0] d);
        wr_t r;
        r.addr = a;
        r.data = d;
        return r;
    endfunction

    // Called at a negedge; presents the byte and returns at the next negedge,
    // after the accepting posedge.
    task automatic send_byte(input logic [7:0] b);
        int g = 0;
        while (!in_ready && g < 50) begin
            in_valid = 1'b0;
            @(negedge clock);
            g++;
        end
        if (g >= 50) begin
            vectors++;
            miscompares++;
            $display("FAIL ready_timeout: in_ready stayed %b", in_ready);
        end
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    task automatic send_all(input int maxgap);
        foreach (fb[i]) begin
            if (maxgap > 0) idle($urandom_range(0, maxgap));
            send_byte(fb[i]);
        end
        in_valid = 1'b0;
        fb.delete();
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clock);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_outputs", {imem_write, imem_address, imem_data, core_start,
                            start_address, busy, error}, 0);
        reset = 1'b0;
        @(negedge clock);
        chk("idle_in_ready", in_ready, 1);
        chk("idle_busy", busy, 0);

        // Frame 1: two instructions at 0x0100
        fb = '{8'hB1, 8'h01, 8'h00, 8'h00, 8'h02, 8'h0A, 8'h12, 8'h03, 8'hFF};
`ifdef LOADER_CHECKSUM_EN
        fb.push_back(8'hDF);
`endif
        exp_wr.push_back(w(16'h0100, 12'hA12));
        exp_wr.push_back(w(16'h0101, 12'h3FF));
        exp_st.push_back(16'h0100);
        send_all(0);
        idle(3);
        chk("f1_error", error, 0);
        chk("f1_busy", busy, 0);
        chk("f1_start_hold", start_address, 16'h0100);

`ifdef LOADER_CHECKSUM_EN
        // Bad checksum: the writes still land, there is no start pulse, and error is set
        fb = '{8'hB1, 8'h01, 8'h00, 8'h00, 8'h02, 8'h0A, 8'h12, 8'h03, 8'hFF, 8'hDC};
        exp_wr.push_back(w(16'h0100, 12'hA12));
        exp_wr.push_back(w(16'h0101, 12'h3FF));
        send_all(0);
        chk("badcs_error", error, 1);
        chk("badcs_busy", busy, 0);
        send_byte(8'hB1);
        in_valid = 1'b0;
        chk("magic_clears_error", error, 0);
        // finish as a count-0 frame at 0x0200
        fb = '{8'h02, 8'h00, 8'h00, 8'h00, 8'hFE};
        exp_st.push_back(16'h0200);
        send_all(0);
        idle(3);
        chk("cnt0_start_hold", start_address, 16'h0200);
`endif

        // Nonzero upper nibble in a hi byte
        fb = '{8'hB1, 8'h03, 8'h00, 8'h00, 8'h02, 8'h00, 8'h55, 8'h1A};
        exp_wr.push_back(w(16'h0300, 12'h055));
        send_all(0);
        chk("badhi_error", error, 1);
        chk("badhi_busy", busy, 0);
        fb = '{8'h00, 8'h12, 8'h34, 8'h0A};
        send_all(0);
        idle(2);
        chk("badhi_ignored_error", error, 1);
        chk("badhi_ignored_busy", busy, 0);

        // Address wrap-around
        fb = '{8'hB1, 8'hFF, 8'hFF, 8'h00, 8'h02, 8'h00, 8'h01, 8'h00, 8'h02};
`ifdef LOADER_CHECKSUM_EN
        fb.push_back(8'hFD);
`endif
        exp_wr.push_back(w(16'hFFFF, 12'h001));
        exp_wr.push_back(w(16'h0000, 12'h002));
        exp_st.push_back(16'hFFFF);
        send_all(0);
        idle(3);
        chk("wrap_error", error, 0);
        chk("wrap_start_hold", start_address, 16'hFFFF);

        // Four instructions with in_valid randomly stalled
        fb = '{8'hB1, 8'h12, 8'h34, 8'h00, 8'h04, 8'h01, 8'h23, 8'h0A, 8'hBC,
               8'h00, 8'h00, 8'h0F, 8'hFF};
`ifdef LOADER_CHECKSUM_EN
        fb.push_back(8'hBE);
`endif
        exp_wr.push_back(w(16'h1234, 12'h123));
        exp_wr.push_back(w(16'h1235, 12'hABC));
        exp_wr.push_back(w(16'h1236, 12'h000));
        exp_wr.push_back(w(16'h1237, 12'hFFF));
        exp_st.push_back(16'h1234);
        send_all(3);
        idle(3);
        chk("rnd_start_hold", start_address, 16'h1234);

        // Count-0 frame
        fb = '{8'hB1, 8'h40, 8'h00, 8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
        fb.push_back(8'hC0);
`endif
        exp_st.push_back(16'h4000);
        send_all(0);
        idle(3);
        chk("cnt0b_start_hold", start_address, 16'h4000);
        chk("cnt0b_busy", busy, 0);

        // Reset between the two bytes of the second pair
        fb = '{8'hB1, 8'h50, 8'h00, 8'h00, 8'h03, 8'h01, 8'h11, 8'h02};
        exp_wr.push_back(w(16'h5000, 12'h111));
        send_all(0);
        chk("mid_busy", busy, 1);
        #2 reset = 1'b1;
        @(negedge clock);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_outputs", {imem_write, imem_address, imem_data, core_start,
                               start_address, busy, error}, 0);
        #2 reset = 1'b0;
        @(negedge clock);
        fb = '{8'hB1, 8'h50, 8'h10, 8'h00, 8'h01, 8'h07, 8'h77};
`ifdef LOADER_CHECKSUM_EN
        fb.push_back(8'h21);
`endif
        exp_wr.push_back(w(16'h5010, 12'h777));
        exp_st.push_back(16'h5010);
        send_all(0);
        idle(3);
        chk("fresh_start_hold", start_address, 16'h5010);
        chk("fresh_error", error, 0);

        chk("pending_writes", exp_wr.size(), 0);
        chk("pending_starts", exp_st.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
